// File: rtl/alu_cmd_ctrl_if.sv
// Command controller bus: UART RX bytes in, ALU drive/result, UART TX bytes out.
// master = controller side, slave = surrounding UART/ALU side.
interface alu_cmd_ctrl_if #(
  parameter int OP_WIDTH  = 16,
  parameter int RES_WIDTH = 32
);
  logic [7:0]           RX_data;
  logic                 RX_valid;
  logic                 ALU_EN;
  logic [3:0]           ALU_FUN;
  logic [OP_WIDTH-1:0]  A;
  logic [OP_WIDTH-1:0]  B;
  logic [RES_WIDTH-1:0] ALU_out;
  logic                 Out_valid;
  logic [7:0]           TX_data;
  logic                 TX_valid;
  logic                 TX_ready;
  logic                 Busy;
  logic                 Overrun;

  modport master (
    input  RX_data, RX_valid,
    output ALU_EN, ALU_FUN, A, B,
    input  ALU_out, Out_valid,
    output TX_data, TX_valid,
    input  TX_ready,
    output Busy, Overrun
  );

  modport slave (
    output RX_data, RX_valid,
    input  ALU_EN, ALU_FUN, A, B,
    output ALU_out, Out_valid,
    input  TX_data, TX_valid,
    output TX_ready,
    input  Busy, Overrun
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Frame assembler in front of the ALU: HEADER, FUN, A bytes, B bytes in;
// result returned LSB-first over a valid/ready byte stream.
module alu_cmd_ctrl #(
  parameter int          OP_WIDTH  = 16,
  parameter int          RES_WIDTH = 32,
  parameter logic [7:0]  HEADER    = 8'hCC
) (
  input logic           CLK,
  input logic           Reset,
  alu_cmd_ctrl_if.master bus
);

  localparam int OPB  = OP_WIDTH / 8;
  localparam int RSB  = RES_WIDTH / 8;
  localparam int MAXB = (OPB > RSB) ? OPB : RSB;
  localparam int CW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0] OP_LAST = CW'(OPB - 1);
  localparam logic [CW-1:0] RS_LAST = CW'(RSB - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FUN,
    S_A,
    S_B,
    S_EXEC,
    S_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           fun_q, fun_d;
  logic [OP_WIDTH-1:0]  a_q, a_d;
  logic [OP_WIDTH-1:0]  b_q, b_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic                 ovr_q, ovr_d;

  logic [CW+2:0]        byte_sel;
  logic                 rx_v;
  logic [7:0]           rx_b;

  assign rx_v     = bus.RX_valid;
  assign rx_b     = bus.RX_data;
  assign byte_sel = {cnt_q, 3'b000};

  // State and datapath registers; reset discards any partial frame or send.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: byte collection, ALU wait, result streaming.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_v && (rx_b == HEADER)) begin
          state_d = S_FUN;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      S_FUN: begin
        if (rx_v) begin
          fun_d   = rx_b[3:0];
          cnt_d   = '0;
          state_d = S_A;
        end
      end
      S_A: begin
        if (rx_v) begin
          a_d[byte_sel +: 8] = rx_b;
          if (cnt_q == OP_LAST) begin
            cnt_d   = '0;
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_B: begin
        if (rx_v) begin
          b_d[byte_sel +: 8] = rx_b;
          if (cnt_q == OP_LAST) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_EXEC: begin
        if (rx_v) ovr_d = 1'b1;
        if (bus.Out_valid) begin
          res_d   = bus.ALU_out;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (rx_v) ovr_d = 1'b1;
        if (bus.TX_ready) begin
          if (cnt_q == RS_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from state; TX byte is held by the counter.
  always_comb begin
    bus.ALU_EN   = (state_q == S_EXEC);
    bus.TX_valid = (state_q == S_SEND);
    bus.Busy     = (state_q != S_IDLE);
    bus.ALU_FUN  = fun_q;
    bus.A        = a_q;
    bus.B        = b_q;
    bus.Overrun  = ovr_q;
    bus.TX_data  = '0;
    if (state_q == S_SEND) bus.TX_data = res_q[byte_sel +: 8];
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: behavioural ALU, byte scoreboard on the
// TX stream, immediate assertions at every comparison.
module tb_alu_cmd_ctrl;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic alu_hold = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en0;

  logic [7:0] exp_q[$];

  alu_cmd_ctrl_if bus ();

  alu_cmd_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_model(
    input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    case (f)
      4'd0: r = {16'd0, a} + {16'd0, b};
      4'd1: r = {16'd0, a} - {16'd0, b};
      4'd2: r = {16'd0, a} * {16'd0, b};
      4'd3: r = (b == 16'd0) ? 32'd0 : {16'd0, a / b};
      4'd4: r = {16'd0, a & b};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign bus.ALU_out   = alu_model(bus.ALU_FUN, bus.A, bus.B);
  assign bus.Out_valid = bus.ALU_EN && !alu_hold;

  always @(posedge CLK) if (bus.ALU_EN) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge CLK);
    if (bus.TX_valid && bus.TX_ready) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", {24'd0, bus.TX_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {24'd0, bus.TX_data}, {24'd0, e});
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_data  = b;
    bus.RX_valid = 1'b1;
    tick();
    bus.RX_valid = 1'b0;
    bus.RX_data  = 8'h00;
  endtask

  task automatic frame(input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b);
    logic [31:0] r;
    r = alu_model(f, a, b);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[i*8 +: 8]);
    send(8'hCC);
    send({4'h0, f});
    send(a[7:0]);
    send(a[15:8]);
    send(b[7:0]);
    send(b[15:8]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.Busy && exp_q.size() == 0) break;
      tick();
    end
    chk("drain_busy", {31'd0, bus.Busy}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    bus.RX_data  = 8'h00;
    bus.RX_valid = 1'b0;
    bus.TX_ready = 1'b1;

    #12;
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_alu_en", {31'd0, bus.ALU_EN}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.TX_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.TX_data}, 32'd0);
    chk("rst_a", {16'd0, bus.A}, 32'd0);
    chk("rst_b", {16'd0, bus.B}, 32'd0);
    chk("rst_overrun", {31'd0, bus.Overrun}, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    tick();

    // Add, TX_ready high
    en0 = en_cnt;
    frame(4'd0, 16'd11, 16'd300);
    chk("add_en_rise", {31'd0, bus.ALU_EN}, 32'd1);
    tick();
    chk("add_en_fall", {31'd0, bus.ALU_EN}, 32'd0);
    chk("add_tx_valid", {31'd0, bus.TX_valid}, 32'd1);
    chk("add_tx_b0", {24'd0, bus.TX_data}, 32'h37);
    wait_idle();
    chk("add_fun", {28'd0, bus.ALU_FUN}, 32'd0);
    chk("add_a", {16'd0, bus.A}, 32'd11);
    chk("add_b", {16'd0, bus.B}, 32'd300);
    chk("add_en_cycles", en_cnt - en0, 32'd1);

    // Multiply with 20 cycles of backpressure
    bus.TX_ready = 1'b0;
    frame(4'd2, 16'h08AE, 16'h08AE);
    tick();
    chk("mul_tx_valid", {31'd0, bus.TX_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("mul_hold_data", {24'd0, bus.TX_data}, 32'h44);
      tick();
    end
    chk("mul_hold_valid", {31'd0, bus.TX_valid}, 32'd1);
    bus.TX_ready = 1'b1;
    wait_idle();

    // Garbage before header
    send(8'h55);
    send(8'h00);
    send(8'hFF);
    chk("garb_busy", {31'd0, bus.Busy}, 32'd0);
    chk("garb_ovr", {31'd0, bus.Overrun}, 32'd0);
    frame(4'd1, 16'd542, 16'd42);
    wait_idle();
    chk("garb_a", {16'd0, bus.A}, 32'd542);
    chk("garb_b", {16'd0, bus.B}, 32'd42);
    chk("garb_ovr2", {31'd0, bus.Overrun}, 32'd0);

    // Overrun during EXEC
    alu_hold = 1'b1;
    frame(4'd0, 16'd1000, 16'd234);
    send(8'h12);
    chk("ovr_set", {31'd0, bus.Overrun}, 32'd1);
    chk("ovr_still_exec", {31'd0, bus.ALU_EN}, 32'd1);
    alu_hold = 1'b0;
    wait_idle();
    chk("ovr_sticky", {31'd0, bus.Overrun}, 32'd1);
    chk("ovr_a", {16'd0, bus.A}, 32'd1000);

    // Header bytes as data; accepted header clears Overrun
    en0 = en_cnt;
    frame(4'd4, 16'hCCCC, 16'hCCCC);
    chk("hdr_ovr_clr", {31'd0, bus.Overrun}, 32'd0);
    chk("hdr_fun", {28'd0, bus.ALU_FUN}, 32'd4);
    chk("hdr_a", {16'd0, bus.A}, 32'h0000_CCCC);
    chk("hdr_b", {16'd0, bus.B}, 32'h0000_CCCC);
    wait_idle();
    chk("hdr_en_cycles", en_cnt - en0, 32'd1);

    // Reset mid-frame
    send(8'hCC);
    send(8'h03);
    send(8'hE7);
    chk("mid_busy", {31'd0, bus.Busy}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("mrst_fun", {28'd0, bus.ALU_FUN}, 32'd0);
    chk("mrst_a", {16'd0, bus.A}, 32'd0);
    chk("mrst_b", {16'd0, bus.B}, 32'd0);
    chk("mrst_tx_valid", {31'd0, bus.TX_valid}, 32'd0);
    chk("mrst_tx_data", {24'd0, bus.TX_data}, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    tick();
    frame(4'd3, 16'd999, 16'd9);
    wait_idle();
    chk("div_a", {16'd0, bus.A}, 32'd999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-frame controller that sits directly upstream of the ALU and downstream of the UART receiver. It assembles byte-serial command frames into an opcode and two operands, then drives the ALU's `ALU_EN`, `ALU_FUN`, `A` and `B` inputs. It captures `ALU_out` on `Out_valid` and returns the result byte-serially to the UART transmitter over a valid/ready handshake.

## Interface
- `OP_WIDTH`, default 16: operand width; each operand is carried as `OP_WIDTH/8` bytes. Must be a multiple of 8.
- `RES_WIDTH`, default 32: ALU result width; returned as `RES_WIDTH/8` bytes. Must be a multiple of 8.
- `HEADER`, default 8'hCC: frame start byte.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `RX_data`  in  8  received byte.
- `RX_valid`  in  1  single-cycle strobe; `RX_data` is valid this cycle.
- `ALU_EN`  out  1  ALU enable.
- `ALU_FUN`  out  4  ALU opcode.
- `A`  out  OP_WIDTH  operand A.
- `B`  out  OP_WIDTH  operand B.
- `ALU_out`  in  RES_WIDTH  ALU result.
- `Out_valid`  in  1  ALU result valid.
- `TX_data`  out  8  result byte to transmitter.
- `TX_valid`  out  1  `TX_data` valid.
- `TX_ready`  in  1  transmitter accepts a byte this cycle.
- `Busy`  out  1  high in every state except IDLE.
- `Overrun`  out  1  sticky flag: a byte was dropped.

## Operation
- Frame, in order: `HEADER`, FUN byte, A bytes (LSB first), B bytes (LSB first).
- FUN byte: bits [3:0] go to `ALU_FUN`; bits [7:4] are ignored.
- States:
  - IDLE: `RX_valid` with `HEADER` goes to GET_FUN. Any other byte is ignored silently.
  - GET_FUN: next byte latched into `ALU_FUN`; go to GET_A.
  - GET_A: byte counter shifts bytes into `A`. After `OP_WIDTH/8` bytes, go to GET_B.
  - GET_B: same for `B`. The last byte goes to EXEC.
  - EXEC: `ALU_EN`=1 and stays 1 until `Out_valid`=1 is sampled. On that edge, capture `ALU_out` into the result register, drop `ALU_EN`, clear the byte counter and go to SEND.
  - SEND: `TX_data` = result byte [counter], LSB first; `TX_valid`=1. A byte transfers on an edge with `TX_valid`&&`TX_ready`; the counter then increments. After byte `RES_WIDTH/8-1` transfers, go to IDLE.
- Inside GET_* states every byte is data, including bytes equal to `HEADER`. There is no resynchronisation.
- `RX_valid` in EXEC or SEND: the byte is dropped and `Overrun` is set. `Overrun` clears only when a `HEADER` is accepted in IDLE.
- `A`, `B` and `ALU_FUN` hold their last values after a frame completes. They are only changed by the next frame.
- `TX_data` must stay stable while `TX_valid`=1 and `TX_ready`=0.

## Timing
- Reset (async assert, sync release): state IDLE; byte counter 0; all outputs 0 (`ALU_EN`, `ALU_FUN`, `A`, `B`, `TX_data`, `TX_valid`, `Busy`, `Overrun`); result register 0.
- Reset asserted mid-frame or mid-send: the partial frame is discarded and any in-flight TX byte is abandoned.
- Each `RX_valid` is consumed on the edge where it is sampled. Back-to-back strobes on consecutive cycles must be accepted.
- Last B byte sampled at edge k: `ALU_EN`=1 from cycle k+1.
- `Out_valid` sampled at edge m: `ALU_EN`=0 and `TX_valid`=1 with byte 0 from cycle m+1.
- With `TX_ready` tied high: one byte per cycle, and IDLE is re-entered one cycle after the last transfer.
- `Out_valid` is ignored outside EXEC.
- `RX_valid` arriving on the same edge that IDLE is re-entered is dropped and sets `Overrun`, because the state is still SEND on that edge.

## Test plan
- Add: frame CC 00 0B 00 2C 01 (11+300), `TX_ready`=1, ALU model with 1-cycle latency -> `ALU_FUN`=0, `A`=11, `B`=300, `ALU_EN` high for exactly 1 cycle; TX bytes 37 01 00 00; `Busy` low afterwards.
- Multiply with backpressure: frame CC 02 AE 08 AE 08, `TX_ready` low for 20 cycles after `TX_valid` rises -> `TX_data`=44 held stable for all 20 cycles; then bytes 44 56 4B 00 (4937284).
- Garbage in IDLE: bytes 55 00 FF before CC 01 1E 02 2A 00 -> garbage ignored, `Overrun`=0; `A`=542, `B`=42; result bytes F4 01 00 00.
- Overrun: send byte 12 during EXEC -> byte dropped, `Overrun`=1, result is unaffected; the next accepted CC clears `Overrun`.
- Reset mid-frame: drop `Reset` after CC 03 E7 -> all outputs 0, state IDLE; a following full div frame CC 03 E7 03 09 00 (999/9) returns 6F 00 00 00.
- Header as data: frame CC 04 CC CC CC CC -> `A`=`B`=16'hCCCC and `ALU_FUN`=4; exactly one ALU execution.
